// File: rtl/sync_ram_dp.sv
// sync_ram_dp: simple-dual-port RAM with byte enables, write-first forwarding and a clear sequencer
module sync_ram_dp #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 8,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;

    assign wr_acc = (state == READY) && wr_en && ({1'b0, wr_addr} < DEPTH_C);
    assign rd_acc = (state == READY) && rd_en;

    // Clear sequencer: walks cnt over every word, then opens the array; clr restarts the walk
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (clr) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            state <= (cnt == LAST) ? READY : INIT;
            ready <= (cnt == LAST);
        end

    // Array write: zero fill while clearing, byte-masked writes otherwise; never reset
    always_ff @(posedge clk)
        if (state == INIT)
            mem[cnt] <= '0;
        else
            for (int i = 0; i < BE_W; i++)
                if (wr_acc && wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];

    // Read word: out-of-range reads give zero, same-address writes win per enabled byte
    always_comb begin
        rd_word = ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
        for (int i = 0; i < BE_W; i++)
            if (wr_acc && wr_addr == rd_addr && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end

    // First read stage: data only moves on an accepted read so it holds otherwise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) s1_data <= rd_word;
        end

    generate
        if (OUT_REG != 0) begin : g_reg
            // Optional output register adding one cycle of latency
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= s1_valid;
                    if (s1_valid) rd_data <= s1_data;
                end
        end else begin : g_noreg
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate
endmodule

// File: tb/tb_sync_ram_dp.sv
// tb_sync_ram_dp: scoreboard bench driving two RAM variants (DEPTH=6/latency 1, DEPTH=8/latency 2)
module tb_sync_ram_dp;
    logic        clk = 0, rst_n = 0, clr = 0, wr_en = 0, rd_en = 0;
    logic [2:0]  wr_addr = 0, rd_addr = 0;
    logic [15:0] wr_data = 0;
    logic [1:0]  wr_be = 0;
    logic        ready0, ready1, rv0, rv1;
    logic [15:0] rd0, rd1;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {logic [15:0] d; int c;} exp_t;
    exp_t q0[$], q1[$];

    logic [15:0] mm [2][8];
    int left [2];
    int dep [2];
    int lat [2];
    logic [15:0] last0 = 0, last1 = 0;

    sync_ram_dp #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(rv0));

    sync_ram_dp #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask

    // Monitors: the head of each queue is due at a specific cycle; any other cycle must be idle
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid0", rv0, 0);
            chk("rst_data0", rd0, 0);
            last0 = 0;
        end else if (q0.size() > 0 && q0[0].c == cyc) begin
            chk("valid0", rv0, 1);
            chk("data0", rd0, q0[0].d);
            last0 = q0[0].d;
            void'(q0.pop_front());
        end else begin
            chk("idle0", rv0, 0);
            chk("hold0", rd0, last0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid1", rv1, 0);
            chk("rst_data1", rd1, 0);
            last1 = 0;
        end else if (q1.size() > 0 && q1[0].c == cyc) begin
            chk("valid1", rv1, 1);
            chk("data1", rd1, q1[0].d);
            last1 = q1[0].d;
            void'(q1.pop_front());
        end else begin
            chk("idle1", rv1, 0);
            chk("hold1", rd1, last1);
        end
    end

    // Reference model for one rising edge of RAM d, given the inputs now on the pins
    task automatic step(input int d);
        logic [15:0] w;
        exp_t e;
        bit rdy, wacc;
        rdy  = (left[d] == 0);
        wacc = rdy && wr_en && (int'(wr_addr) < dep[d]);
        if (rdy && rd_en) begin
            w = (int'(rd_addr) < dep[d]) ? mm[d][rd_addr] : 16'h0;
            if (wacc && wr_addr == rd_addr)
                for (int i = 0; i < 2; i++) if (wr_be[i]) w[8*i +: 8] = wr_data[8*i +: 8];
            e.d = w;
            e.c = cyc + lat[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (wacc)
            for (int i = 0; i < 2; i++) if (wr_be[i]) mm[d][wr_addr][8*i +: 8] = wr_data[8*i +: 8];
        if (!rdy) begin
            mm[d][dep[d] - left[d]] = 16'h0;
            left[d]--;
        end
        if (clr) left[d] = dep[d];
    endtask

    task automatic cyc_do(input bit rs, input bit c, input bit we, input logic [2:0] wa,
                          input logic [15:0] wd, input logic [1:0] be, input bit re, input logic [2:0] ra);
        @(negedge clk);
        #1;
        chk("ready0", ready0, left[0] == 0);
        chk("ready1", ready1, left[1] == 0);
        rst_n = rs; clr = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (!rs) begin
            q0.delete();
            q1.delete();
            left[0] = dep[0];
            left[1] = dep[1];
        end else begin
            step(0);
            step(1);
        end
    endtask

    task automatic idle();
        cyc_do(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc_do(1, 0, 1, a, d, be, 0, 0);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc_do(1, 0, 0, 0, 0, 0, 1, a);
    endtask

    task automatic pulse_clr();
        cyc_do(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cycle();
        cyc_do(1, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        dep[0] = 6; dep[1] = 8; lat[0] = 1; lat[1] = 2;
        left[0] = 6; left[1] = 8;
        for (int d = 0; d < 2; d++) for (int a = 0; a < 8; a++) mm[d][a] = 16'h0;
        repeat (3) cyc_do(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc_do(1, 0, 1, 3'(i), 16'hDEAD, 2'b11, 1, 3'(i));
        for (int a = 0; a < 8; a++) rd(3'(a));
        wr(3, 16'h00A5, 2'b11);
        rd(3);
        idle(); idle();
        wr(2, 16'h1122, 2'b11);
        wr(2, 16'hAABB, 2'b01);
        rd(2);
        wr(5, 16'h00FF, 2'b11);
        cyc_do(1, 0, 1, 5, 16'h1234, 2'b10, 1, 5);
        cyc_do(1, 0, 1, 5, 16'h5678, 2'b11, 1, 4);
        wr(7, 16'hBEEF, 2'b11);
        rd(7);
        rd(5);
        for (int a = 0; a < 8; a++) wr(3'(a), 16'hFFFF, 2'b11);
        pulse_clr();
        repeat (3) idle();
        pulse_clr();
        repeat (10) idle();
        for (int a = 0; a < 8; a++) rd(3'(a));
        repeat (300) rand_cycle();
        repeat (10) idle();
        rd(1);
        repeat (2) cyc_do(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (200) rand_cycle();
        repeat (12) idle();
        for (int a = 0; a < 8; a++) rd(3'(a));
        repeat (4) idle();
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_ram_dp.md
# sync_ram_dp

Parametrised simple-dual-port synchronous RAM: the next generation of the team's 8x8 single-port RAM. It provides one write port with byte enables and one independent read port with optional output register. Read-during-write forwarding is built in, and a hardware clear sequencer zeroes the array after reset or on request. It serves as the general storage macro for buffers and register files in the design.

## Interface
- DATA_W, 8: data width in bits; must be a multiple of 8.
- ADDR_W, 3: address width.
- DEPTH, 8: number of words, 1 ≤ DEPTH ≤ 2**ADDR_W.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register for latency 2.
- BE_W (derived): DATA_W/8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  request a full array clear; single-cycle pulse or level.
- ready  out  1  high when the array is usable (state READY).
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid strobe, one cycle per accepted read.

## Operation
- FSM states: INIT and READY. Reset puts the FSM in INIT with clear counter cnt=0.
- INIT:
  - Each cycle writes all-zero to mem[cnt], then cnt increments.
  - When cnt==DEPTH-1 is written, the next state is READY.
  - INIT lasts exactly DEPTH cycles.
  - wr_en and rd_en are ignored: no array write, no rd_valid.
- READY:
  - ready=1.
  - clr=1 sends the next state to INIT with cnt=0.
  - clr=1 during INIT restarts cnt at 0.
- A write is accepted when the state is READY, wr_en=1 and wr_addr<DEPTH.
  - Only bytes with wr_be[i]=1 are updated.
  - wr_be=0 performs no change.
- A read is accepted when the state is READY and rd_en=1.
  - If rd_addr ≥ DEPTH, the read returns all-zero data but still produces rd_valid.
- Read-during-write, same cycle with rd_addr==wr_addr and both accepted (write-first): the returned word takes
  - bytes with wr_be set from wr_data,
  - remaining bytes from the old array content.
- A read and a write to different addresses in the same cycle are independent.
- Requests in the same cycle as clr while in READY are accepted normally. Their reads complete, but returned data may be zeroed afterwards by the clear.
- Pipeline stages are not flushed by clr.
- rd_data holds its last value when rd_valid=0.
- The memory array is not reset by rst_n; only the clear sequencer zeroes it.

## Timing
- Reset values: ready=0, rd_valid=0, rd_data=0, FSM=INIT, cnt=0, OUT_REG pipeline valid=0.
- After rst_n deasserts: first clear write at edge 1; ready rises after edge DEPTH (visible in cycle DEPTH+1).
- Read latency:
  - OUT_REG=0: rd_en accepted at edge N gives rd_data/rd_valid after edge N.
  - OUT_REG=1: after edge N+1.
- Back-to-back reads every cycle give full throughput, with rd_valid high continuously.
- Write data is visible to a read accepted at the same edge (forwarding) or at any later edge.
- rst_n asserted mid-operation: immediately clears rd_valid, rd_data and ready; in-flight reads are lost; the FSM re-enters INIT.
- Clear sequence length is independent of ADDR_W; cnt never exceeds DEPTH-1.

## Test plan
- Reset release, DEPTH=8: ready=0 for 8 cycles then 1; rd_en pulses during INIT produce no rd_valid; afterwards every address reads 0x00.
- OUT_REG=0 vs OUT_REG=1:
  - Write 0xA5 to addr 3.
  - Read addr 3: rd_valid and rd_data=0xA5 appear 1 cycle later and 2 cycles later respectively.
  - Streaming reads of addr 0..7 give 8 consecutive rd_valid cycles.
- Byte enables, DATA_W=32:
  - Write 0x11223344, be=4'hF, to addr 2.
  - Write 0xAABBCCDD, be=4'b0101, to addr 2.
  - Read addr 2 returns 0x11BB33DD.
- Same-cycle read/write, addr 5 holding 0x00FF:
  - Write 0x1234 with be=2'b10 and read addr 5 in the same cycle.
  - Read returns 0x12FF.
  - A read at a different address in the same cycle returns that address's old data.
- DEPTH=6, ADDR_W=3:
  - Write to addr 7 is dropped.
  - Read addr 7 returns 0 with rd_valid=1.
  - Read addr 5 is unaffected.
- Clear and reset:
  - Fill the array with 0xFF, pulse clr: ready low for DEPTH cycles, then all reads return 0.
  - clr re-pulsed mid-INIT extends INIT to DEPTH cycles from the re-pulse.
  - rst_n asserted with a read in flight under OUT_REG=1: no rd_valid appears.
